i2s_sample_arbiter: RTL and testbench

Collects decoded PCM samples from NUM_SRC I2S microphone receiver front-ends and merges them into one tagged sample stream with a valid/ready handshake. It gates capture with an enable/arm/drain state machine, so every capture session starts on a source-0 left sample. It also reports per-source overflow. It sits between the receiver front-ends and the downstream FIFO/DMA. All inputs are synchronous to clk.

---
 rtl/i2s_sample_arbiter.sv | 118 +++++++++++
 tb/tb_i2s_sample_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_arbiter.sv
// i2s_sample_arbiter: merges per-source I2S samples into one round-robin tagged stream,
// gated by an enable/arm/drain session FSM with sticky per-source overflow flags.
module i2s_sample_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_BITS = 24,
  parameter int CNT_BITS  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_SRC*DATA_BITS-1:0] src_data,
  input  logic [NUM_SRC-1:0]           src_ch,
  input  logic [NUM_SRC-1:0]           src_valid,
  output logic [DATA_BITS-1:0]         m_data,
  output logic [$clog2(NUM_SRC)-1:0]   m_src,
  output logic                         m_ch,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic                         ovf_clr,
  output logic [NUM_SRC-1:0]           overflow,
  output logic                         busy,
  output logic [CNT_BITS-1:0]          sample_count
);
  localparam int SW = $clog2(NUM_SRC);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] sd_q [NUM_SRC];
  logic [DATA_BITS-1:0] sd_d [NUM_SRC];
  logic [NUM_SRC-1:0] sch_q, sch_d, pend_q, pend_d, ovf_q, ovf_d, acc, gnt, load;
  logic [SW-1:0] rr_q, rr_d, gi, idx, ms_q, ms_d;
  logic [DATA_BITS-1:0] md_q, md_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic mc_q, mc_d, mv_q, mv_d, busy_q, hit, ld, xfer;

  assign xfer = mv_q & m_ready;
  assign ld   = ~mv_q | m_ready;
  // ARM only lets a source-0 left sample through, so every session starts aligned
  assign acc = state_q == RUN ? src_valid :
               (state_q == ARM && enable) ? {{(NUM_SRC-1){1'b0}}, src_valid[0] & ~src_ch[0]} : '0;

  always_comb begin
    hit = 1'b0;
    gi  = '0;
    idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = SW'((int'(rr_q) + k) % NUM_SRC);
      if (!hit && pend_q[idx]) begin
        hit = 1'b1;
        gi  = idx;
      end
    end
    gnt = (hit && ld) ? NUM_SRC'(1) << gi : '0;
  end

  // a slot granted this cycle counts as free, so a same-cycle strobe replaces it without overflow
  always_comb begin
    load   = acc & ~(pend_q & ~gnt);
    pend_d = (pend_q & ~gnt) | load;
    sch_d  = (sch_q & ~load) | (src_ch & load);
    ovf_d  = (ovf_q & ~{NUM_SRC{ovf_clr}}) | (acc & pend_q & ~gnt);
    for (int i = 0; i < NUM_SRC; i++)
      sd_d[i] = load[i] ? src_data[i*DATA_BITS +: DATA_BITS] : sd_q[i];
  end

  always_comb begin
    mv_d  = ld ? hit : mv_q;
    md_d  = (ld && hit) ? sd_q[gi] : md_q;
    ms_d  = (ld && hit) ? gi : ms_q;
    mc_d  = (ld && hit) ? sch_q[gi] : mc_q;
    rr_d  = (ld && hit) ? (gi == SW'(NUM_SRC-1) ? '0 : gi + 1'b1) : rr_q;
    cnt_d = (state_q == IDLE && enable) ? '0 : cnt_q + CNT_BITS'(xfer);
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ARM;
      ARM:     if (!enable) state_d = IDLE; else if (acc[0]) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      default: if (pend_q == '0 && ld) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_SRC; i++) sd_q[i] <= '0;
      sch_q  <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
      md_q   <= '0;
      ms_q   <= '0;
      mc_q   <= 1'b0;
      mv_q   <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_SRC; i++) sd_q[i] <= sd_d[i];
      sch_q  <= sch_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      md_q   <= md_d;
      ms_q   <= ms_d;
      mc_q   <= mc_d;
      mv_q   <= mv_d;
      cnt_q  <= cnt_d;
      busy_q <= state_d != IDLE;
    end
  end

  assign m_data       = md_q;
  assign m_src        = ms_q;
  assign m_ch         = mc_q;
  assign m_valid      = mv_q;
  assign overflow     = ovf_q;
  assign busy         = busy_q;
  assign sample_count = cnt_q;
endmodule

// File: tb/tb_i2s_sample_arbiter.sv
// tb_i2s_sample_arbiter: directed and random stimulus against a behavioural session/slot model;
// expected samples are queued by the model and popped by a monitor on each accepted transfer.
module tb_i2s_sample_arbiter;
  localparam int NS = 4, DB = 24, CB = 16;
  logic clk = 1'b0;
  logic rst_n, enable, m_ready, ovf_clr, m_ch, m_valid, busy;
  logic [NS*DB-1:0] src_data;
  logic [NS-1:0] src_ch, src_valid, overflow;
  logic [DB-1:0] m_data;
  logic [1:0] m_src;
  logic [CB-1:0] sample_count;
  int checks = 0, errors = 0;

  typedef struct packed {logic [1:0] src; logic ch; logic [DB-1:0] data;} smp_t;
  smp_t exp_q[$];
  smp_t got;
  // model: ph 0 idle, 1 arm, 2 run, 3 drain
  int ph, mrr, w;
  logic [NS-1:0] mpend, movf;
  smp_t mslot [NS];
  logic mov, done, a, arm_hit;
  logic [CB-1:0] mcnt;

  always #5 clk = ~clk;

  i2s_sample_arbiter #(.NUM_SRC(NS), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_data(src_data), .src_ch(src_ch),
    .src_valid(src_valid), .m_data(m_data), .m_src(m_src), .m_ch(m_ch), .m_valid(m_valid),
    .m_ready(m_ready), .ovf_clr(ovf_clr), .overflow(overflow), .busy(busy),
    .sample_count(sample_count)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, e, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; mrr = 0; mov = 1'b0; movf = '0; mcnt = '0; mpend = '0;
      exp_q.delete();
    end else begin
      done = (mpend == '0) && (!mov || m_ready);
      if (mov && m_ready) mcnt++;
      if (!mov || m_ready) begin
        w = -1;
        for (int k = 0; k < NS; k++)
          if (w < 0 && mpend[(mrr + k) % NS]) w = (mrr + k) % NS;
        mov = w >= 0;
        if (w >= 0) begin
          exp_q.push_back(mslot[w]);
          mpend[w] = 1'b0;
          mrr = (w + 1) % NS;
        end
      end
      if (ovf_clr) movf = '0;
      arm_hit = 1'b0;
      for (int i = 0; i < NS; i++) begin
        a = src_valid[i] && (ph == 2 || (ph == 1 && enable && i == 0 && !src_ch[0]));
        if (a && i == 0 && ph == 1) arm_hit = 1'b1;
        if (a && mpend[i]) movf[i] = 1'b1;
        else if (a) begin
          mpend[i] = 1'b1;
          mslot[i] = {2'(i), src_ch[i], src_data[i*DB +: DB]};
        end
      end
      case (ph)
        0: if (enable) begin ph = 1; mcnt = '0; end
        1: if (!enable) ph = 0; else if (arm_hit) ph = 2;
        2: if (!enable) ph = 3;
        default: if (done) ph = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("m_valid", m_valid, mov);
    chk("busy", busy, ph != 0);
    chk("overflow", overflow, movf);
    chk("sample_count", sample_count, mcnt);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output got src %0d data %0h, expected none", m_src, m_data);
      end else begin
        got = exp_q.pop_front();
        chk("out_src", m_src, got.src);
        chk("out_ch", m_ch, got.ch);
        chk("out_data", m_data, got.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    src_valid = '0;
    ovf_clr = 1'b0;
  endtask

  task automatic strobe(input int s, input logic ch, input logic [DB-1:0] d);
    src_valid[s] = 1'b1;
    src_ch[s] = ch;
    src_data[s*DB +: DB] = d;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b1; ovf_clr = 1'b0;
    src_valid = '0; src_ch = '0; src_data = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", sample_count, 0);
    // arm alignment: right sample skipped, left sample starts the session
    enable = 1'b1;
    tick(); tick();
    strobe(0, 1'b1, 24'h111111); tick();
    strobe(0, 1'b0, 24'h222222); tick();
    tick();
    chk("arm_first_valid", m_valid, 1);
    chk("arm_first_data", m_data, 24'h222222);
    chk("arm_first_src", m_src, 0);
    chk("arm_first_ch", m_ch, 0);
    tick(); tick();
    // round robin: park the pointer after src3, then all four at once
    strobe(3, 1'b0, 24'h33); repeat (3) tick();
    for (int s = 0; s < NS; s++) strobe(s, 1'b0, 24'hA0 + 24'(s));
    tick();
    repeat (6) tick();
    chk("rr_count", sample_count, 6);
    // backpressure and overflow
    m_ready = 1'b0;
    strobe(1, 1'b0, 24'h01); tick(); tick();
    strobe(2, 1'b0, 24'h10); tick();
    strobe(2, 1'b0, 24'h20); tick();
    chk("ovf_set", overflow, 4'b0100);
    chk("bp_hold_data", m_data, 24'h01);
    m_ready = 1'b1;
    repeat (3) tick();
    ovf_clr = 1'b1; tick();
    chk("ovf_clr", overflow, 0);
    // same-cycle replace
    strobe(1, 1'b1, 24'h50); tick();
    strobe(1, 1'b1, 24'h51); tick();
    repeat (3) tick();
    chk("replace_no_ovf", overflow, 0);
    // random traffic
    repeat (400) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      m_ready = $urandom_range(0, 9) < 7;
      ovf_clr = $urandom_range(0, 19) == 0;
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 9) < 3) strobe(s, 1'($urandom_range(0, 1)), 24'($urandom));
      tick();
    end
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 100 && busy; i++) tick();
    chk("random_idle", busy, 0);
    // drain
    enable = 1'b1; tick(); tick();
    strobe(0, 1'b0, 24'h300); tick();
    repeat (3) tick();
    m_ready = 1'b0;
    strobe(1, 1'b0, 24'h301); strobe(2, 1'b1, 24'h302); strobe(3, 1'b0, 24'h303); tick();
    tick();
    enable = 1'b0; tick();
    strobe(0, 1'b0, 24'h3FF); tick();
    chk("drain_busy", busy, 1);
    tick();
    chk("drain_busy2", busy, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("drain_idle", busy, 0);
    chk("drain_count", sample_count, 4);
    chk("drain_queue_empty", exp_q.size(), 0);
    // reset mid-run
    enable = 1'b1; tick(); tick();
    strobe(0, 1'b0, 24'h400); tick();
    repeat (3) tick();
    m_ready = 1'b0;
    strobe(2, 1'b0, 24'h410); tick(); tick();
    chk("pre_rst_valid", m_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", m_valid, 0);
    chk("async_rst_data", m_data, 0);
    chk("async_rst_src", m_src, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", sample_count, 0);
    enable = 1'b0; m_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_no_stale", m_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
